reg_status_ctrl: RTL and testbench
==================================

Name: reg_status_ctrl

Overview:
- Sequences the architectural register file for the out-of-order core. Owns the per-register busy bit and ROB tag (rename status).
- Drives the register file's read and write ports: reads at dispatch, writes at ROB commit.
- Returns per-source operand value or producer tag to the reservation-station stage.
- Zero-initialises the register file after reset and clears rename status on flush.

Parameters:
REG_CARD_WIDTH, 5, architectural register index width (2^5 = 32 registers)
ROB_TAG_WIDTH, 4, ROB entry tag width
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  mispredict flush; clears all busy bits
dispatch_valid  in  1  dispatch request
dispatch_ready  out  1  controller can accept a dispatch this cycle
dispatch_rs1  in  REG_CARD_WIDTH  source 1 index
dispatch_rs2  in  REG_CARD_WIDTH  source 2 index
dispatch_rd_en  in  1  instruction writes rd
dispatch_rd  in  REG_CARD_WIDTH  destination index
dispatch_tag  in  ROB_TAG_WIDTH  ROB tag allocated to this instruction
commit_valid  in  1  ROB commits a register write
commit_rd  in  REG_CARD_WIDTH  committed destination
commit_tag  in  ROB_TAG_WIDTH  ROB tag of the committing entry
commit_data  in  DATA_WIDTH  committed value
rf_re  out  1  register file read enable
rf_raddr1  out  REG_CARD_WIDTH  register file read address 1
rf_raddr2  out  REG_CARD_WIDTH  register file read address 2
rf_rdata1  in  DATA_WIDTH  registered read data 1, valid the cycle after rf_re
rf_rdata2  in  DATA_WIDTH  registered read data 2, valid the cycle after rf_re
rf_we  out  1  register file write enable
rf_waddr  out  REG_CARD_WIDTH  register file write address
rf_wdata  out  DATA_WIDTH  register file write data
op_valid  out  1  operand bundle valid
op_ready_in  in  1  downstream accepts the bundle
op1_ready  out  1  source 1 value available
op1_val  out  DATA_WIDTH  source 1 value, meaningful only when op1_ready = 1
op1_tag  out  ROB_TAG_WIDTH  source 1 producer tag, meaningful only when op1_ready = 0
op2_ready  out  1  source 2 value available
op2_val  out  DATA_WIDTH  source 2 value, meaningful only when op2_ready = 1
op2_tag  out  ROB_TAG_WIDTH  source 2 producer tag, meaningful only when op2_ready = 0

Behaviour:
- Reset:
  - state = INIT, init counter = 0, all busy = 0, all tags = 0.
  - op_valid = 0, dispatch_ready = 0, rf_we = 0, rf_re = 0.
  - All data, address and tag outputs = 0.
- FSM:
  - INIT: each cycle rf_we = 1, rf_waddr = counter, rf_wdata = 0; counter increments.
  - After 32 writes (counter wraps from 31), INIT -> RUN. RUN is left only by reset.
  - During INIT: commit and dispatch are ignored, dispatch_ready = 0.
- dispatch_ready (RUN) = !op_valid || op_ready_in. A dispatch is accepted when dispatch_valid && dispatch_ready && !flush.
- Accept cycle T:
  - rf_re = 1, rf_raddr1/2 = rs1/rs2, driven combinationally.
  - Busy/tag of each source is snapshotted from the pre-edge status.
  - At cycle T+1: op_valid = 1; opN_ready = !busy[rsN]; opN_tag = tag[rsN]; opN_val = rf_rdataN, or the bypass value.
- Commit bypass: in cycle T, if commit_valid && commit_rd == rsN && rsN != 0 && status tag == commit_tag, then opN_ready = 1 and opN_val = commit_data (the register file write lands on the same edge as the read).
- Source equals rd in the same dispatch: the source uses the pre-rename status.
- Rename on accept with dispatch_rd_en && rd != 0: busy[rd] <= 1, tag[rd] <= dispatch_tag.
- Commit (RUN):
  - rf_we = 1, rf_waddr = commit_rd, rf_wdata = commit_data, combinationally, when commit_rd != 0.
  - busy[commit_rd] <= 0 only if tag[commit_rd] == commit_tag.
  - Same-cycle rename of the same register wins: busy stays 1 and the new tag is written.
- x0: never busy, never renamed, never written; op value for index 0 = 0, ready = 1.
- Backpressure: while op_valid && !op_ready_in, all op outputs are held stable, including values (latch rf_rdata), and no dispatch is accepted.
- Tags are snapshots. A producer committing after the snapshot is resolved by the reservation station via CDB/ROB, not by this block.
- Flush (RUN):
  - All busy <= 0 at the edge.
  - Any dispatch in the same cycle is dropped: no rename, and op_valid = 0 next cycle.
  - op_valid <= 0.
  - A commit in the same cycle still writes the register file.
- Reset mid-operation: immediate return to INIT; the zero-fill is redone.

Test Plan:
- Reset release -> rf_we high 32 consecutive cycles, waddr 0..31, wdata 0; dispatch_ready rises the cycle after waddr = 31.
- Commit x5 = 0xDEADBEEF (no rename) and x6 = 0x12345678, tag 2, to a non-busy register; then dispatch rs1 = 5, rs2 = 0 -> next cycle op1_ready = 1, op1_val = 0xDEADBEEF, op2_ready = 1, op2_val = 0.
- Dispatch rd = 7 tag 3; then dispatch rs1 = 7 -> op1_ready = 0, op1_tag = 3. Commit x7 tag 3 in the same cycle as a dispatch reading x7 -> op1_ready = 1, op1_val = commit_data.
- Rename x8 tag 4, then x8 tag 9; commit x8 tag 4 -> x8 stays busy with tag 9. Commit tag 9 -> busy cleared.
- Hold op_ready_in = 0 for 3 cycles with op_valid = 1 -> dispatch_ready = 0; op outputs unchanged even after a commit to the same register.
- Rename x1..x4, assert flush together with dispatch_valid -> no op_valid next cycle; subsequent reads of x1..x4 return ready = 1. Dispatch with rd = 0 -> x0 still reads 0, ready.

Source files
------------

// File: rtl/reg_status_ctrl_if.sv
// Signal bundle between the rename/status controller and its neighbours:
// dispatch, ROB commit, register-file ports and the operand bundle to the RS stage.
interface reg_status_ctrl_if #(
    parameter int unsigned REG_CARD_WIDTH = 5,
    parameter int unsigned ROB_TAG_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH     = 32
);
    logic                      flush;

    logic                      dispatch_valid;
    logic                      dispatch_ready;
    logic [REG_CARD_WIDTH-1:0] dispatch_rs1;
    logic [REG_CARD_WIDTH-1:0] dispatch_rs2;
    logic                      dispatch_rd_en;
    logic [REG_CARD_WIDTH-1:0] dispatch_rd;
    logic [ROB_TAG_WIDTH-1:0]  dispatch_tag;

    logic                      commit_valid;
    logic [REG_CARD_WIDTH-1:0] commit_rd;
    logic [ROB_TAG_WIDTH-1:0]  commit_tag;
    logic [DATA_WIDTH-1:0]     commit_data;

    logic                      rf_re;
    logic [REG_CARD_WIDTH-1:0] rf_raddr1;
    logic [REG_CARD_WIDTH-1:0] rf_raddr2;
    logic [DATA_WIDTH-1:0]     rf_rdata1;
    logic [DATA_WIDTH-1:0]     rf_rdata2;
    logic                      rf_we;
    logic [REG_CARD_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]     rf_wdata;

    logic                      op_valid;
    logic                      op_ready_in;
    logic                      op1_ready;
    logic [DATA_WIDTH-1:0]     op1_val;
    logic [ROB_TAG_WIDTH-1:0]  op1_tag;
    logic                      op2_ready;
    logic [DATA_WIDTH-1:0]     op2_val;
    logic [ROB_TAG_WIDTH-1:0]  op2_tag;

    modport slave (
        input  flush,
        input  dispatch_valid, dispatch_rs1, dispatch_rs2, dispatch_rd_en, dispatch_rd, dispatch_tag,
        input  commit_valid, commit_rd, commit_tag, commit_data,
        input  rf_rdata1, rf_rdata2, op_ready_in,
        output dispatch_ready,
        output rf_re, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output op_valid, op1_ready, op1_val, op1_tag, op2_ready, op2_val, op2_tag
    );

    modport master (
        output flush,
        output dispatch_valid, dispatch_rs1, dispatch_rs2, dispatch_rd_en, dispatch_rd, dispatch_tag,
        output commit_valid, commit_rd, commit_tag, commit_data,
        output rf_rdata1, rf_rdata2, op_ready_in,
        input  dispatch_ready,
        input  rf_re, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  op_valid, op1_ready, op1_val, op1_tag, op2_ready, op2_val, op2_tag
    );
endinterface

// File: rtl/reg_status_ctrl.sv
// Architectural register file sequencer: zero-fill after reset, per-register
// busy/ROB-tag rename status, dispatch operand lookup with commit bypass.
module reg_status_ctrl #(
    parameter int unsigned REG_CARD_WIDTH = 5,
    parameter int unsigned ROB_TAG_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input logic              clk,
    input logic              rst,
    reg_status_ctrl_if.slave bus
);
    localparam int unsigned NUM_REGS = 1 << REG_CARD_WIDTH;
    localparam logic [REG_CARD_WIDTH-1:0] X0 = '0;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                    state;
    logic [REG_CARD_WIDTH-1:0] init_cnt;
    logic [NUM_REGS-1:0]       busy;
    logic [ROB_TAG_WIDTH-1:0]  tag [NUM_REGS];

    logic                      op_valid_q;
    logic                      fresh_q;
    logic                      op1_ready_q, op2_ready_q;
    logic [ROB_TAG_WIDTH-1:0]  op1_tag_q, op2_tag_q;
    logic                      op1_fixed_q, op2_fixed_q;
    logic [DATA_WIDTH-1:0]     op1_fixed_val_q, op2_fixed_val_q;
    logic [DATA_WIDTH-1:0]     op1_hold_q, op2_hold_q;

    logic                      run_c, ready_c, accept_c, rename_c;
    logic                      commit_wr_c, commit_hit_c, byp1_c, byp2_c;
    logic [DATA_WIDTH-1:0]     op1_val_c, op2_val_c;

    assign run_c        = (state == ST_RUN);
    assign ready_c      = run_c && (!op_valid_q || bus.op_ready_in);
    assign accept_c     = bus.dispatch_valid && ready_c && !bus.flush;
    assign rename_c     = accept_c && bus.dispatch_rd_en && (bus.dispatch_rd != X0);
    assign commit_wr_c  = run_c && bus.commit_valid && (bus.commit_rd != X0);
    assign commit_hit_c = commit_wr_c && (tag[bus.commit_rd] == bus.commit_tag);

    // A commit landing on the same edge as the RF read would be missed by the read
    assign byp1_c = bus.commit_valid && (bus.commit_rd == bus.dispatch_rs1) &&
                    (bus.dispatch_rs1 != X0) && (tag[bus.dispatch_rs1] == bus.commit_tag);
    assign byp2_c = bus.commit_valid && (bus.commit_rd == bus.dispatch_rs2) &&
                    (bus.dispatch_rs2 != X0) && (tag[bus.dispatch_rs2] == bus.commit_tag);

    // Init/run sequencer; RUN is left only through reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + REG_CARD_WIDTH'(1);
            if (&init_cnt) begin
                state <= ST_RUN;
            end
        end
    end

    // Register-file port drive: zero-fill walk in INIT, commits and dispatch reads in RUN
    always_comb begin
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.rf_re     = 1'b0;
        bus.rf_raddr1 = '0;
        bus.rf_raddr2 = '0;
        if (rst && (state == ST_INIT)) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = init_cnt;
        end else if (commit_wr_c) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.commit_rd;
            bus.rf_wdata = bus.commit_data;
        end
        if (accept_c) begin
            bus.rf_re     = 1'b1;
            bus.rf_raddr1 = bus.dispatch_rs1;
            bus.rf_raddr2 = bus.dispatch_rs2;
        end
    end

    // Rename status; a same-cycle rename overrides the commit's busy clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag[i] <= '0;
            end
        end else if (run_c) begin
            if (bus.flush) begin
                busy <= '0;
            end else begin
                if (commit_hit_c) begin
                    busy[bus.commit_rd] <= 1'b0;
                end
                if (rename_c) begin
                    busy[bus.dispatch_rd] <= 1'b1;
                end
            end
            if (rename_c) begin
                tag[bus.dispatch_rd] <= bus.dispatch_tag;
            end
        end
    end

    // Operand bundle; value comes from RF read data only in the cycle right after the read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid_q      <= 1'b0;
            fresh_q         <= 1'b0;
            op1_ready_q     <= 1'b0;
            op2_ready_q     <= 1'b0;
            op1_tag_q       <= '0;
            op2_tag_q       <= '0;
            op1_fixed_q     <= 1'b0;
            op2_fixed_q     <= 1'b0;
            op1_fixed_val_q <= '0;
            op2_fixed_val_q <= '0;
            op1_hold_q      <= '0;
            op2_hold_q      <= '0;
        end else begin
            fresh_q <= accept_c;
            if (fresh_q) begin
                op1_hold_q <= op1_val_c;
                op2_hold_q <= op2_val_c;
            end
            if (bus.flush) begin
                op_valid_q <= 1'b0;
            end else if (accept_c) begin
                op_valid_q      <= 1'b1;
                op1_ready_q     <= (bus.dispatch_rs1 == X0) || !busy[bus.dispatch_rs1] || byp1_c;
                op2_ready_q     <= (bus.dispatch_rs2 == X0) || !busy[bus.dispatch_rs2] || byp2_c;
                op1_tag_q       <= tag[bus.dispatch_rs1];
                op2_tag_q       <= tag[bus.dispatch_rs2];
                op1_fixed_q     <= (bus.dispatch_rs1 == X0) || byp1_c;
                op2_fixed_q     <= (bus.dispatch_rs2 == X0) || byp2_c;
                op1_fixed_val_q <= byp1_c ? bus.commit_data : '0;
                op2_fixed_val_q <= byp2_c ? bus.commit_data : '0;
            end else if (bus.op_ready_in) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        op1_val_c = op1_hold_q;
        op2_val_c = op2_hold_q;
        if (fresh_q) begin
            op1_val_c = op1_fixed_q ? op1_fixed_val_q : bus.rf_rdata1;
            op2_val_c = op2_fixed_q ? op2_fixed_val_q : bus.rf_rdata2;
        end
    end

    assign bus.dispatch_ready = ready_c;
    assign bus.op_valid       = op_valid_q;
    assign bus.op1_ready      = op1_ready_q;
    assign bus.op2_ready      = op2_ready_q;
    assign bus.op1_tag        = op1_tag_q;
    assign bus.op2_tag        = op2_tag_q;
    assign bus.op1_val        = op1_val_c;
    assign bus.op2_val        = op2_val_c;
endmodule

// File: tb/tb_reg_status_ctrl.sv
// Bench for reg_status_ctrl: directed scenarios plus randomized traffic against
// an architectural model (values, busy, tags) and a simple register-file model.
module tb_reg_status_ctrl;
    localparam int unsigned RW = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_status_ctrl_if #(.REG_CARD_WIDTH(RW), .ROB_TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

    reg_status_ctrl #(.REG_CARD_WIDTH(RW), .ROB_TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Register file with registered read data, left uninitialised until zero-filled
    logic [DW-1:0] rf_mem [NR];
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
        if (bus.rf_re) begin
            bus.rf_rdata1 <= rf_mem[bus.rf_raddr1];
            bus.rf_rdata2 <= rf_mem[bus.rf_raddr2];
        end
    end

    // Architectural model
    logic [DW-1:0] m_val [NR];
    bit            m_busy [NR];
    logic [TW-1:0] m_tag [NR];
    int            m_init_left;
    bit            e_valid, e_r1, e_r2;
    logic [DW-1:0] e_v1, e_v2;
    logic [TW-1:0] e_t1, e_t2;

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        m_init_left = NR;
        e_valid = 1'b0;
    endtask

    task automatic set_in(input bit dv, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                          input bit rd_en, input logic [RW-1:0] rd, input logic [TW-1:0] dtag,
                          input bit cv, input logic [RW-1:0] crd, input logic [TW-1:0] ctag,
                          input logic [DW-1:0] cdata, input bit fl, input bit ordy);
        bus.dispatch_valid = dv;  bus.dispatch_rs1 = rs1; bus.dispatch_rs2 = rs2;
        bus.dispatch_rd_en = rd_en; bus.dispatch_rd = rd; bus.dispatch_tag = dtag;
        bus.commit_valid = cv; bus.commit_rd = crd; bus.commit_tag = ctag; bus.commit_data = cdata;
        bus.flush = fl; bus.op_ready_in = ordy;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic dispatch(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                            input bit rd_en, input logic [RW-1:0] rd, input logic [TW-1:0] dtag);
        set_in(1, rs1, rs2, rd_en, rd, dtag, 0, 0, 0, 0, 0, 1);
    endtask

    // What a source should resolve to, from the status seen before the edge
    task automatic resolve(input logic [RW-1:0] rs, output bit r, output logic [DW-1:0] v,
                           output logic [TW-1:0] t);
        t = m_tag[rs];
        if (rs == 0) begin
            r = 1'b1; v = '0;
        end else if (bus.commit_valid && bus.commit_rd == rs && m_tag[rs] == bus.commit_tag) begin
            r = 1'b1; v = bus.commit_data;
        end else begin
            r = !m_busy[rs]; v = m_val[rs];
        end
    endtask

    // Advance the model by the inputs currently driven, then cross one clock edge
    task automatic clock_model();
        bit run, acc;
        run = (m_init_left == 0);
        acc = run && bus.dispatch_valid && (!e_valid || bus.op_ready_in) && !bus.flush;
        if (bus.flush) e_valid = 1'b0;
        else if (acc) begin
            e_valid = 1'b1;
            resolve(bus.dispatch_rs1, e_r1, e_v1, e_t1);
            resolve(bus.dispatch_rs2, e_r2, e_v2, e_t2);
        end else if (bus.op_ready_in) e_valid = 1'b0;
        if (run && bus.commit_valid && bus.commit_rd != 0) begin
            m_val[bus.commit_rd] = bus.commit_data;
            if (m_tag[bus.commit_rd] == bus.commit_tag) m_busy[bus.commit_rd] = 1'b0;
        end
        if (acc && bus.dispatch_rd_en && bus.dispatch_rd != 0) begin
            m_busy[bus.dispatch_rd] = 1'b1;
            m_tag[bus.dispatch_rd]  = bus.dispatch_tag;
        end
        if (run && bus.flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        if (!run) m_init_left--;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #2;
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL rst_op_valid got=%b exp=0", bus.op_valid); end
        total++; if (bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL rst_dispatch_ready got=%b exp=0", bus.dispatch_ready); end
        total++; if (bus.rf_we !== 1'b0 || bus.rf_re !== 1'b0) begin bad++; $display("FAIL rst_rf_en we=%b re=%b exp=0,0", bus.rf_we, bus.rf_re); end
        total++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin bad++; $display("FAIL rst_rf_w addr=%h data=%h exp=0", bus.rf_waddr, bus.rf_wdata); end
        total++; if (bus.op1_val !== 32'd0 || bus.op2_val !== 32'd0 || bus.op1_tag !== 4'd0 || bus.op2_tag !== 4'd0)
            begin bad++; $display("FAIL rst_op_fields v1=%h v2=%h t1=%h t2=%h exp=0", bus.op1_val, bus.op2_val, bus.op1_tag, bus.op2_tag); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NR; i++) begin
            total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(i) || bus.rf_wdata !== 32'd0)
                begin bad++; $display("FAIL init_walk i=%0d we=%b addr=%0d data=%h exp=1,%0d,0", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i); end
            total++; if (bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL init_ready i=%0d got=%b exp=0", i, bus.dispatch_ready); end
            clock_model();
        end
        total++; if (bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL run_ready got=%b exp=1", bus.dispatch_ready); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL run_idle_we got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_commit_read();
        set_in(0, 0, 0, 0, 0, 0, 1, 5, 0, 32'hDEADBEEF, 0, 1);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL commit_port we=%b addr=%0d data=%h exp=1,5,deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        clock_model();
        set_in(0, 0, 0, 0, 0, 0, 1, 6, 2, 32'h12345678, 0, 1);
        clock_model();
        dispatch(5, 0, 0, 0, 0);
        total++; if (bus.rf_re !== 1'b1 || bus.rf_raddr1 !== 5'd5 || bus.rf_raddr2 !== 5'd0)
            begin bad++; $display("FAIL read_port re=%b a1=%0d a2=%0d exp=1,5,0", bus.rf_re, bus.rf_raddr1, bus.rf_raddr2); end
        clock_model();
        total++; if (bus.op_valid !== 1'b1 || bus.op1_ready !== 1'b1 || bus.op1_val !== 32'hDEADBEEF)
            begin bad++; $display("FAIL read_x5 v=%b r=%b val=%h exp=1,1,deadbeef", bus.op_valid, bus.op1_ready, bus.op1_val); end
        total++; if (bus.op2_ready !== 1'b1 || bus.op2_val !== 32'd0)
            begin bad++; $display("FAIL read_x0 r=%b val=%h exp=1,0", bus.op2_ready, bus.op2_val); end
        dispatch(6, 5, 0, 0, 0);
        clock_model();
        total++; if (bus.op1_val !== 32'h12345678 || bus.op2_val !== 32'hDEADBEEF)
            begin bad++; $display("FAIL read_x6_x5 v1=%h v2=%h exp=12345678,deadbeef", bus.op1_val, bus.op2_val); end
        idle(); clock_model();
    endtask

    task automatic test_rename();
        dispatch(0, 0, 1, 7, 3);
        clock_model();
        dispatch(7, 0, 0, 0, 0);
        clock_model();
        total++; if (bus.op1_ready !== 1'b0 || bus.op1_tag !== 4'd3)
            begin bad++; $display("FAIL busy_x7 r=%b tag=%0d exp=0,3", bus.op1_ready, bus.op1_tag); end
        set_in(1, 7, 7, 0, 0, 0, 1, 7, 3, 32'hCAFE0007, 0, 1);
        clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op1_val !== 32'hCAFE0007 || bus.op2_val !== 32'hCAFE0007)
            begin bad++; $display("FAIL bypass_x7 r=%b v1=%h v2=%h exp=1,cafe0007", bus.op1_ready, bus.op1_val, bus.op2_val); end
        dispatch(7, 0, 0, 0, 0);
        clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op1_val !== 32'hCAFE0007)
            begin bad++; $display("FAIL after_commit_x7 r=%b v=%h exp=1,cafe0007", bus.op1_ready, bus.op1_val); end
        idle(); clock_model();
    endtask

    task automatic test_double_rename();
        dispatch(0, 0, 1, 8, 4); clock_model();
        dispatch(0, 0, 1, 8, 9); clock_model();
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 4, 32'hAAAA0004, 0, 1); clock_model();
        dispatch(8, 0, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b0 || bus.op1_tag !== 4'd9)
            begin bad++; $display("FAIL stale_commit_x8 r=%b tag=%0d exp=0,9", bus.op1_ready, bus.op1_tag); end
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 9, 32'hBBBB0009, 0, 1); clock_model();
        dispatch(8, 0, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op1_val !== 32'hBBBB0009)
            begin bad++; $display("FAIL final_commit_x8 r=%b v=%h exp=1,bbbb0009", bus.op1_ready, bus.op1_val); end
        // Rename and clearing commit on the same edge
        dispatch(0, 0, 1, 8, 5); clock_model();
        set_in(1, 0, 0, 1, 8, 11, 1, 8, 5, 32'hCCCC0005, 0, 1); clock_model();
        dispatch(8, 0, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b0 || bus.op1_tag !== 4'd11)
            begin bad++; $display("FAIL rename_wins_x8 r=%b tag=%0d exp=0,11", bus.op1_ready, bus.op1_tag); end
        set_in(0, 0, 0, 0, 0, 0, 1, 8, 11, 32'hDDDD000B, 0, 1); clock_model();
    endtask

    task automatic test_backpressure();
        set_in(1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clock_model();
        for (int c = 0; c < 3; c++) begin
            set_in(1, 6, 6, 1, 10, 7, 1, 5, 0, 32'h55555555, 0, 0);
            total++; if (bus.dispatch_ready !== 1'b0 || bus.rf_re !== 1'b0)
                begin bad++; $display("FAIL bp_ready c=%0d rdy=%b re=%b exp=0,0", c, bus.dispatch_ready, bus.rf_re); end
            clock_model();
            total++; if (bus.op_valid !== 1'b1 || bus.op1_ready !== 1'b1 || bus.op1_val !== 32'hDEADBEEF || bus.op2_val !== 32'hCAFE0007)
                begin bad++; $display("FAIL bp_hold c=%0d v=%b r=%b v1=%h v2=%h exp=1,1,deadbeef,cafe0007", c, bus.op_valid, bus.op1_ready, bus.op1_val, bus.op2_val); end
        end
        idle(); clock_model();
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.op_valid); end
        dispatch(5, 10, 0, 0, 0); clock_model();
        total++; if (bus.op1_val !== 32'h55555555 || bus.op2_ready !== 1'b1)
            begin bad++; $display("FAIL bp_after v1=%h r2=%b exp=55555555,1", bus.op1_val, bus.op2_ready); end
        idle(); clock_model();
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            dispatch(0, 0, 1, 5'(r), 4'(r)); clock_model();
        end
        set_in(1, 1, 2, 1, 9, 6, 1, 2, 0, 32'h22222222, 1, 1);
        total++; if (bus.rf_re !== 1'b0 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd2)
            begin bad++; $display("FAIL flush_ports re=%b we=%b wa=%0d exp=0,1,2", bus.rf_re, bus.rf_we, bus.rf_waddr); end
        clock_model();
        total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", bus.op_valid); end
        dispatch(1, 9, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op2_ready !== 1'b1 || bus.op1_val !== 32'd0 || bus.op2_val !== 32'd0)
            begin bad++; $display("FAIL flush_x1_x9 r1=%b r2=%b v1=%h v2=%h exp=1,1,0,0", bus.op1_ready, bus.op2_ready, bus.op1_val, bus.op2_val); end
        dispatch(3, 2, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op2_ready !== 1'b1 || bus.op2_val !== 32'h22222222)
            begin bad++; $display("FAIL flush_x3_x2 r1=%b r2=%b v2=%h exp=1,1,22222222", bus.op1_ready, bus.op2_ready, bus.op2_val); end
        idle(); clock_model();
    endtask

    task automatic test_x0();
        set_in(1, 0, 0, 1, 0, 5, 1, 0, 0, 32'hFFFFFFFF, 0, 1);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL x0_write we=%b exp=0", bus.rf_we); end
        clock_model();
        dispatch(0, 4, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op1_val !== 32'd0 || bus.op2_ready !== 1'b1)
            begin bad++; $display("FAIL x0_read r=%b v=%h r2=%b exp=1,0,1", bus.op1_ready, bus.op1_val, bus.op2_ready); end
        idle(); clock_model();
    endtask

    task automatic test_random();
        bit dv, rd_en, cv, fl, ordy, exp_rdy, exp_acc;
        logic [RW-1:0] rs1, rs2, rd, crd;
        logic [TW-1:0] dtag, ctag;
        logic [DW-1:0] cdata;
        for (int n = 0; n < 600; n++) begin
            dv = ($urandom_range(0, 9) < 7);
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            rd_en = $urandom_range(0, 1) != 0; rd = 5'($urandom_range(0, 7)); dtag = 4'($urandom);
            cv = $urandom_range(0, 1) != 0; crd = 5'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 2) != 0) ? m_tag[crd] : 4'($urandom);
            cdata = $urandom;
            fl = ($urandom_range(0, 31) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            set_in(dv, rs1, rs2, rd_en, rd, dtag, cv, crd, ctag, cdata, fl, ordy);
            exp_rdy = (m_init_left == 0) && (!e_valid || ordy);
            exp_acc = exp_rdy && dv && !fl;
            total++; if (bus.dispatch_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.dispatch_ready, exp_rdy); end
            total++; if (bus.rf_re !== exp_acc) begin bad++; $display("FAIL rnd_re n=%0d got=%b exp=%b", n, bus.rf_re, exp_acc); end
            clock_model();
            total++; if (bus.op_valid !== e_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.op_valid, e_valid); end
            if (e_valid) begin
                total++; if (bus.op1_ready !== e_r1) begin bad++; $display("FAIL rnd_r1 n=%0d got=%b exp=%b", n, bus.op1_ready, e_r1); end
                total++;
                if (e_r1) begin if (bus.op1_val !== e_v1) begin bad++; $display("FAIL rnd_v1 n=%0d got=%h exp=%h", n, bus.op1_val, e_v1); end end
                else if (bus.op1_tag !== e_t1) begin bad++; $display("FAIL rnd_t1 n=%0d got=%h exp=%h", n, bus.op1_tag, e_t1); end
                total++; if (bus.op2_ready !== e_r2) begin bad++; $display("FAIL rnd_r2 n=%0d got=%b exp=%b", n, bus.op2_ready, e_r2); end
                total++;
                if (e_r2) begin if (bus.op2_val !== e_v2) begin bad++; $display("FAIL rnd_v2 n=%0d got=%h exp=%h", n, bus.op2_val, e_v2); end end
                else if (bus.op2_tag !== e_t2) begin bad++; $display("FAIL rnd_t2 n=%0d got=%h exp=%h", n, bus.op2_tag, e_t2); end
            end
        end
        idle(); clock_model();
    endtask

    task automatic test_reset_midop();
        set_in(0, 0, 0, 0, 0, 0, 1, 5, m_tag[5], 32'h77777777, 0, 1);
        clock_model();
        dispatch(0, 0, 1, 5, 2);
        clock_model();
        rst = 1'b0;
        #1;
        total++; if (bus.op_valid !== 1'b0 || bus.dispatch_ready !== 1'b0)
            begin bad++; $display("FAIL midrst_async v=%b rdy=%b exp=0,0", bus.op_valid, bus.dispatch_ready); end
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NR; i++) begin
            total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(i))
                begin bad++; $display("FAIL midrst_walk i=%0d we=%b addr=%0d exp=1,%0d", i, bus.rf_we, bus.rf_waddr, i); end
            clock_model();
        end
        dispatch(5, 0, 0, 0, 0); clock_model();
        total++; if (bus.op1_ready !== 1'b1 || bus.op1_val !== 32'd0)
            begin bad++; $display("FAIL midrst_x5 r=%b v=%h exp=1,0", bus.op1_ready, bus.op1_val); end
        idle(); clock_model();
    endtask

    initial begin
        test_reset();
        test_commit_read();
        test_rename();
        test_double_rename();
        test_backpressure();
        test_flush();
        test_x0();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
